// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between the display line prefetcher and a
// host write port. When a line is requested, the block reads LW = 2^LB_AW consecutive
// words into the line buffer. Host writes are taken one at a time, but only when no
// fetch is active.
//
// Ports
//   clk_vga, rst                  pixel clock, asynchronous active-high reset
//   line_req, line_num            one-cycle line prefetch request and line index
//   wr_req, wr_addr, wr_data      host write request, held until wr_ack
//   wr_ack                        one-cycle write-done pulse
//   mem_en/we/addr/wdata          registered RAM command
//   mem_rdata                     RAM read data, valid one cycle after a read
//   lb_we, lb_addr, lb_wdata      line-buffer write port
//   busy                          FSM not idle
//   underrun                      sticky: a line request was dropped
//
// state | meaning
// IDLE  | waiting; a line request takes priority over a host write
// FETCH | issuing one RAM read per cycle, words 0..LW-1 of the line
// DRAIN | no RAM access; captures the last read word into the line buffer
// WRITE | single-cycle host write to RAM, wr_ack high

module vga_fb_arbiter #(
    parameter int  DATA_W = 16,
    parameter int  LB_AW  = 6,
    localparam int ADDR_W = 10 + LB_AW
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic              line_req,
    input  logic [9:0]        line_num,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [LB_AW-1:0]  lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              busy,
    output logic              underrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [LB_AW-1:0]  wc, wc_nx, wc_inc, lb_addr_nx;
    logic [ADDR_W-1:0] base, base_nx, fetch_base, mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic              mem_en_nx, mem_we_nx, wr_ack_nx, lb_we_nx, underrun_nx;
    logic              last_word, rd_issued, fetch_start;

    assign fetch_base = {line_num, {LB_AW{1'b0}}};
    assign wc_inc     = wc + 1'b1;
    assign last_word  = (wc == {LB_AW{1'b1}});
    assign rd_issued  = mem_en & ~mem_we;

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A line request that lands in WRITE is taken straight into FETCH at the next
    // edge. That removes the idle gap, and no request has to be parked anywhere.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (line_req)      state_nx = FETCH;
                     else if (wr_req)   state_nx = WRITE;
            FETCH:   if (last_word)     state_nx = DRAIN;
            DRAIN:                      state_nx = IDLE;
            WRITE:   if (line_req)      state_nx = FETCH;
                     else               state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // RAM outputs are registered, so this block computes the values for the next
    // cycle from the state transition that is being taken.
    always_comb begin
        fetch_start  = (state_nx == FETCH) && (state != FETCH);
        mem_en_nx    = 1'b0;
        mem_we_nx    = 1'b0;
        wr_ack_nx    = 1'b0;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        wc_nx        = wc;
        base_nx      = base;
        if (fetch_start) begin
            base_nx     = fetch_base;
            wc_nx       = '0;
            mem_en_nx   = 1'b1;
            mem_addr_nx = fetch_base;
        end else if (state == FETCH && state_nx == FETCH) begin
            wc_nx       = wc_inc;
            mem_en_nx   = 1'b1;
            mem_addr_nx = base + ADDR_W'(wc_inc);
        end else if (state_nx == WRITE) begin
            mem_en_nx    = 1'b1;
            mem_we_nx    = 1'b1;
            mem_addr_nx  = wr_addr;
            mem_wdata_nx = wr_data;
            wr_ack_nx    = 1'b1;
        end
        // wc still holds the index of the read being issued this cycle. That read's
        // data returns next cycle, so the index is captured alongside it.
        lb_we_nx    = rd_issued;
        lb_addr_nx  = rd_issued ? wc : lb_addr;
        underrun_nx = underrun | (line_req & ((state == FETCH) | (state == DRAIN)));
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            wc        <= '0;
            base      <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_ack    <= 1'b0;
            lb_we     <= 1'b0;
            lb_addr   <= '0;
            underrun  <= 1'b0;
        end else begin
            wc        <= wc_nx;
            base      <= base_nx;
            mem_en    <= mem_en_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            wr_ack    <= wr_ack_nx;
            lb_we     <= lb_we_nx;
            lb_addr   <= lb_addr_nx;
            underrun  <= underrun_nx;
        end
    end

    // RAM read data arrives in the same cycle as lb_we. It is gated so that the
    // line-buffer data reads as zero whenever no line-buffer write is happening.
    assign lb_wdata = lb_we ? mem_rdata : '0;
    assign busy     = (state != IDLE);

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL be the framebuffer and line-buffer word width in bits.
REQ-002 Parameter LB_AW, default 6, SHALL be the line-buffer address width; words per line LW = 2^LB_AW (default 64).
REQ-003 Derived width ADDR_W SHALL equal 10 + LB_AW (default 16).
REQ-004 clk_vga  in  1  pixel clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 line_req  in  1  single-cycle pulse requesting a prefetch of one display line.
REQ-007 line_num  in  10  index of the line to fetch; sampled only in the cycle line_req=1.
REQ-008 wr_req  in  1  write request; held high with wr_addr/wr_data stable until wr_ack.
REQ-009 wr_addr  in  ADDR_W  framebuffer write address.
REQ-010 wr_data  in  DATA_W  framebuffer write data.
REQ-011 wr_ack  out  1  one-cycle pulse; the write was performed this cycle.
REQ-012 mem_en  out  1  single-port framebuffer RAM enable.
REQ-013 mem_we  out  1  RAM write enable (valid only with mem_en=1).
REQ-014 mem_addr  out  ADDR_W  RAM address.
REQ-015 mem_wdata  out  DATA_W  RAM write data.
REQ-016 mem_rdata  in  DATA_W  RAM read data, valid exactly one cycle after a read (mem_en=1, mem_we=0).
REQ-017 lb_we  out  1  line-buffer write strobe.
REQ-018 lb_addr  out  LB_AW  line-buffer word address.
REQ-019 lb_wdata  out  DATA_W  line-buffer write data.
REQ-020 busy  out  1  high whenever state is not IDLE.
REQ-021 underrun  out  1  sticky flag: a line request was lost.

Function
REQ-022 The FSM SHALL have states IDLE, FETCH, DRAIN, WRITE; all RAM outputs SHALL be registered.
REQ-023 IDLE: line_req=1 or pending fetch flag set -> FETCH (line wins over wr_req); else wr_req=1 -> WRITE; else stay.
REQ-024 On entering FETCH the block SHALL latch base = line_num << LB_AW (from line_req or the pending-line register) and clear word counter wc to 0.
REQ-025 In each FETCH cycle: mem_en=1, mem_we=0, mem_addr=base+wc; wc increments; after wc=LW-1 is issued -> DRAIN.
REQ-026 One cycle after each read issue: lb_we=1, lb_addr=word index of that read, lb_wdata=mem_rdata.
REQ-027 DRAIN SHALL last exactly one cycle (captures the final word), then -> IDLE; mem_en=0 in DRAIN.
REQ-028 Latency: line_req at cycle t in IDLE -> reads at t+1..t+LW, lb_we at t+2..t+LW+1, DRAIN at t+LW+1, IDLE at t+LW+2.
REQ-029 WRITE SHALL last one cycle: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1; then -> IDLE.
REQ-030 line_req during WRITE SHALL set the pending flag and latch line_num; FETCH follows WRITE with no idle gap.
REQ-031 line_req during FETCH or DRAIN, or while pending is already set, SHALL be dropped and SHALL set underrun; the in-progress fetch continues unaffected.
REQ-032 wr_req SHALL never be granted in FETCH, DRAIN or back-to-back with a pending fetch; max write wait = 1 fetch + 2 cycles.
REQ-033 Address arithmetic SHALL be modulo 2^ADDR_W; line_num=1023 fetches 0xFFC0..0xFFFF (defaults) with no wrap into line 0.
REQ-034 Outside the cases above, mem_en, mem_we, wr_ack, lb_we SHALL be 0.

Reset
REQ-035 rst=1 SHALL immediately force state=IDLE, wc=0, pending=0, underrun=0, and busy, mem_en, mem_we, wr_ack, lb_we=0; mem_addr, mem_wdata, lb_addr, lb_wdata=0.
REQ-036 rst asserted mid-FETCH SHALL abort the fetch; no further lb_we occurs after release until a new line_req.
REQ-037 underrun SHALL clear only on rst.

Verification
REQ-038 line_req, line_num=5 in IDLE -> reads at 0x0140..0x017F on t+1..t+64; lb_we t+2..t+65, lb_addr 0..63 with matching data; busy low at t+66.
REQ-039 wr_req held, wr_addr=0x1234, wr_data=0xBEEF, IDLE -> one RAM write to 0x1234 with wr_ack=1 next cycle, then idle.
REQ-040 wr_req and line_req same cycle in IDLE -> FETCH first; wr_ack exactly one cycle after DRAIN.
REQ-041 line_req during WRITE (line_num=7) -> FETCH of 0x01C0.. starts the cycle after wr_ack; underrun stays 0.
REQ-042 Second line_req at t+10 of a fetch -> underrun=1 and held; current fetch completes; line_num=1023 fetch ends at 0xFFFF.
REQ-043 rst pulse at t+20 of a fetch -> all outputs 0 immediately; no lb_we after release; a new line_req then fetches normally.
